nois_system_onchip_mem_stream_writer: RTL

NOIS_SYSTEM_ONCHIP_MEM_STREAM_WRITER -- requirements
Module: nois_system_onchip_mem_stream_writer

---
 rtl/nois_system_onchip_mem_stream_writer_if.sv | 26 ++
 rtl/nois_system_onchip_mem_stream_writer.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/nois_system_onchip_mem_stream_writer_if.sv
// Stream-sink and on-chip memory write bus shared by the stream writer and its environment.
// The master side accepts stream words and drives the memory port; the slave side is the opposite end.
interface nois_system_onchip_mem_stream_writer_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
);
  logic [DATA_W-1:0]   snk_data;
  logic                snk_valid;
  logic                snk_ready;
  logic [ADDR_W-1:0]   address;
  logic [DATA_W/8-1:0] byteenable;
  logic                chipselect;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic                clken;

  modport master (
    input  snk_data, snk_valid,
    output snk_ready, address, byteenable, chipselect, write, writedata, clken
  );

  modport slave (
    output snk_data, snk_valid,
    input  snk_ready, address, byteenable, chipselect, write, writedata, clken
  );
endinterface

// File: rtl/nois_system_onchip_mem_stream_writer.sv
// Writes stream words into consecutive on-chip memory addresses, one pass or repeated ring passes.
// Every accepted word becomes exactly one write cycle on the following clock.
module nois_system_onchip_mem_stream_writer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              stop,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  input  logic              ring_en,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count,
  nois_system_onchip_mem_stream_writer_if.master bus
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t              state_q, state_d;
  logic                snk_ready_q, snk_ready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                write_q, write_d;
  logic [ADDR_W-1:0]   address_q, address_d;
  logic [DATA_W-1:0]   writedata_q, writedata_d;
  logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic                ring_q, ring_d;

  logic                accept;
  logic [ADDR_W:0]     count_inc;
  logic                last_word;

  assign accept    = bus.snk_valid && snk_ready_q;
  assign count_inc = count_q + {{ADDR_W{1'b0}}, 1'b1};
  assign last_word = (count_inc == len_q);

  always_comb begin
    state_d     = state_q;
    snk_ready_d = snk_ready_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    write_d     = accept;
    address_d   = address_q;
    writedata_d = writedata_q;
    cur_addr_d  = cur_addr_q;
    count_d     = count_q;
    base_d      = base_q;
    len_d       = len_q;
    ring_d      = ring_q;

    // count tracks the write cycle it causes, so it reads L while the final write is on the bus
    if (accept) begin
      address_d   = cur_addr_q;
      writedata_d = bus.snk_data;
      cur_addr_d  = cur_addr_q + ADDR_W'(1);
      count_d     = count_inc;
    end

    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          base_d      = base_addr;
          len_d       = (length == '0) ? {1'b1, {ADDR_W{1'b0}}} : length;
          ring_d      = ring_en;
          cur_addr_d  = base_addr;
          count_d     = '0;
          state_d     = RUN;
          snk_ready_d = 1'b1;
          busy_d      = 1'b1;
        end
      end
      RUN: begin
        if (accept && last_word) begin
          // a stop arriving with the last word still finishes the pass, but ends the ring
          state_d     = FLUSH;
          snk_ready_d = 1'b0;
          done_d      = 1'b1;
          if (stop) ring_d = 1'b0;
        end else if (stop) begin
          state_d     = IDLE;
          snk_ready_d = 1'b0;
          busy_d      = 1'b0;
        end
      end
      FLUSH: begin
        if (ring_q && !stop) begin
          state_d     = RUN;
          cur_addr_d  = base_q;
          count_d     = '0;
          snk_ready_d = 1'b1;
        end else begin
          state_d     = IDLE;
          busy_d      = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        snk_ready_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      snk_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      write_q     <= 1'b0;
      address_q   <= '0;
      writedata_q <= '0;
      cur_addr_q  <= '0;
      count_q     <= '0;
      base_q      <= '0;
      len_q       <= '0;
      ring_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      snk_ready_q <= snk_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      write_q     <= write_d;
      address_q   <= address_d;
      writedata_q <= writedata_d;
      cur_addr_q  <= cur_addr_d;
      count_q     <= count_d;
      base_q      <= base_d;
      len_q       <= len_d;
      ring_q      <= ring_d;
    end
  end

  assign bus.snk_ready  = snk_ready_q;
  assign bus.address    = address_q;
  assign bus.writedata  = writedata_q;
  assign bus.chipselect = write_q;
  assign bus.write      = write_q;
  assign bus.byteenable = '1;
  assign bus.clken      = 1'b1;
  assign busy           = busy_q;
  assign done           = done_q;
  assign count          = count_q;

endmodule
